// File: rtl/config_jtag_pkg.sv
// Shared constants and state encoding for the two-wire configuration link.
// Used by both the transmitter and the matching receiver.
package config_jtag_pkg;

    localparam int          SYNC_LEN   = 16;
    localparam logic [15:0] SYNC_WRITE = 16'hFAB1;
    localparam logic [15:0] SYNC_RESET = 16'hFAB0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RSTF  = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/config_jtag_shifter.sv
// Parallel-load MSB-first shift register with a down-counter and last-bit flag.
// out_bit is the register MSB, so a loaded word is visible on the load edge.
module config_jtag_shifter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic [CW-1:0]    load_cnt,
    input  logic             shift,
    input  logic             clear,
    output logic             out_bit,
    output logic             last
);

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clear) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_dat;
            cnt  <= load_cnt;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt - 1'b1;
        end
    end

    assign out_bit = sreg[WIDTH-1];
    assign last    = (cnt == '0);

endmodule

// File: rtl/config_jtag_tx.sv
// Serial transmitter: frames 32-bit words or link resets onto tms/data_bit, MSB first.
// Bit i of a frame accepted at edge N is driven after edge N+i; frame ends with a forced idle gap.
// cmd_ready is high only in IDLE; cmd_valid may be held high for back-to-back frames.
module config_jtag_tx #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] SYNC_WRITE = config_jtag_pkg::SYNC_WRITE,
    parameter logic [15:0] SYNC_RESET = config_jtag_pkg::SYNC_RESET,
    parameter int          GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_reset,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  tms,
    output logic                  data_bit,
    output logic                  busy,
    output logic                  done
);

    import config_jtag_pkg::*;

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Write frames right-align the sync so it completes together with the payload.
    localparam logic [DATA_WIDTH-1:0] TMS_WRITE_INIT = DATA_WIDTH'(SYNC_WRITE);
    localparam logic [DATA_WIDTH-1:0] TMS_RESET_INIT = DATA_WIDTH'(SYNC_RESET) << (DATA_WIDTH - SYNC_LEN);

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   gap_cnt;
    logic            done_q;
    logic            accept;
    logic            in_frame;
    logic            frame_end;
    logic            gap_end;
    logic            tms_bit;
    logic            tms_last;
    logic            pay_bit;
    logic            pay_last;
    logic [DATA_WIDTH-1:0] tms_load;
    logic [DATA_WIDTH-1:0] pay_load;
    logic [CW-1:0]   cnt_load;

    assign accept    = cmd_valid && (state == IDLE);
    assign in_frame  = (state == WRITE) || (state == RSTF);
    assign frame_end = ((state == WRITE) && pay_last) || ((state == RSTF) && tms_last);
    assign gap_end   = (state == GAP) && (gap_cnt == '0);

    assign tms_load = cmd_is_reset ? TMS_RESET_INIT : TMS_WRITE_INIT;
    assign pay_load = cmd_is_reset ? '0 : cmd_data;
    assign cnt_load = cmd_is_reset ? CW'(SYNC_LEN - 1) : CW'(DATA_WIDTH - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept)    state_nxt = cmd_is_reset ? RSTF : WRITE;
            WRITE: if (frame_end) state_nxt = GAP;
            RSTF:  if (frame_end) state_nxt = GAP;
            GAP:   if (gap_end)   state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                gap_cnt <= GW'(GAP_CYCLES - 1);
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Clearing both shifters on the last edge makes the gap drive zeros.
    config_jtag_shifter #(.WIDTH(DATA_WIDTH), .CW(CW)) u_tms_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_dat (tms_load),
        .load_cnt (cnt_load),
        .shift    (in_frame && !frame_end),
        .clear    (frame_end),
        .out_bit  (tms_bit),
        .last     (tms_last)
    );

    config_jtag_shifter #(.WIDTH(DATA_WIDTH), .CW(CW)) u_pay_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_dat (pay_load),
        .load_cnt (cnt_load),
        .shift    (in_frame && !frame_end),
        .clear    (frame_end),
        .out_bit  (pay_bit),
        .last     (pay_last)
    );

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = done_q;
        tms       = tms_bit;
        data_bit  = pay_bit;
    end

endmodule

// File: tb/tb_config_jtag_tx.sv
// Bench for config_jtag_tx: a model receiver records strobes, scoreboard queues hold expected words.
module tb_config_jtag_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, a_is_rst = 1'b0, a_ready, a_tms, a_dat, a_busy, a_done;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0, b_is_rst = 1'b0, b_ready, b_tms, b_dat, b_busy, b_done;
    logic [31:0] b_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] ta = '0, tb_s = '0;
    logic [31:0] da = '0, db = '0;
    logic [31:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    int rst_evt_a = 0, rst_evt_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    config_jtag_tx dut_a (
        .clk(clk), .reset(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_is_reset(a_is_rst), .cmd_data(a_data), .tms(a_tms), .data_bit(a_dat),
        .busy(a_busy), .done(a_done)
    );

    config_jtag_tx #(.GAP_CYCLES(1)) dut_b (
        .clk(clk), .reset(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_is_reset(b_is_rst), .cmd_data(b_data), .tms(b_tms), .data_bit(b_dat),
        .busy(b_busy), .done(b_done)
    );

    // Model receiver: commits on a full 16-bit sync match, same reset as the transmitter.
    always @(negedge clk) begin
        if (!rst_n) begin
            ta <= '0; da <= '0; tb_s <= '0; db <= '0;
        end else begin
            if ({ta[14:0], a_tms} == 16'hFAB1) got_a.push_back({da[30:0], a_dat});
            if ({ta[14:0], a_tms} == 16'hFAB0) rst_evt_a++;
            if ({tb_s[14:0], b_tms} == 16'hFAB1) got_b.push_back({db[30:0], b_dat});
            if ({tb_s[14:0], b_tms} == 16'hFAB0) rst_evt_b++;
            ta <= {ta[14:0], a_tms}; da <= {da[30:0], a_dat};
            tb_s <= {tb_s[14:0], b_tms}; db <= {db[30:0], b_dat};
        end
    end

    task automatic send(input bit sel, input logic r, input logic [31:0] d, output int n);
        bit ok = 1'b0;
        n = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sel) begin b_valid = 1'b1; b_is_rst = r; b_data = d; ok = b_ready; end
            else     begin a_valid = 1'b1; a_is_rst = r; a_data = d; ok = a_ready; end
            if (ok) begin n = cyc + 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout: ready never seen, required 1"); end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        bit idle = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) begin
            @(negedge clk);
            idle = sel ? !b_busy : !a_busy;
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL idle_timeout: busy stuck, required 0"); end
    endtask

    task automatic capture(input bit sel, input int nbits, output logic [31:0] dv, output logic [31:0] tv);
        dv = '0; tv = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            dv = {dv[30:0], sel ? b_dat : a_dat};
            tv = {tv[30:0], sel ? b_tms : a_tms};
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({a_tms, a_dat, a_busy, a_done} !== 4'b0) begin errors++;
            $display("FAIL reset_outs: got %b required 0000", {a_tms, a_dat, a_busy, a_done}); end
        checks++; if (a_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b required 1", a_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({a_busy, a_done, b_busy, b_done} !== 4'b0) begin errors++;
            $display("FAIL post_reset_idle: got %b required 0000", {a_busy, a_done, b_busy, b_done}); end
    endtask

    task automatic test_write();
        int n;
        logic [31:0] dv, tv, e, g;
        exp_a.push_back(32'h12345678);
        send(1'b0, 1'b0, 32'h12345678, n);
        capture(1'b0, 32, dv, tv);
        checks++; if (dv !== 32'h12345678) begin errors++; $display("FAIL write_data: got %h required 12345678", dv); end
        checks++; if (tv !== 32'h0000FAB1) begin errors++; $display("FAIL write_tms: got %h required 0000fab1", tv); end
        @(negedge clk);
        checks++; if (cyc != n + 32 || {a_done, a_tms, a_dat} !== 3'b100) begin errors++;
            $display("FAIL write_done: cyc %0d done/tms/dat %b required cyc %0d 100", cyc, {a_done, a_tms, a_dat}, n + 32); end
        @(negedge clk);
        checks++; if ({a_done, a_busy, a_ready} !== 3'b010) begin errors++;
            $display("FAIL write_gap: done/busy/ready %b required 010", {a_done, a_busy, a_ready}); end
        @(negedge clk);
        checks++; if ({a_busy, a_ready} !== 2'b01) begin errors++;
            $display("FAIL write_idle: busy/ready %b required 01", {a_busy, a_ready}); end
        checks++; if (got_a.size() != exp_a.size()) begin errors++;
            $display("FAIL write_strobes: got %0d required %0d", got_a.size(), exp_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL write_word: got %h required %h", g, e); end
        end
        exp_a.delete(); got_a.delete();
    endtask

    task automatic test_reset_frame();
        int n;
        int ev0 = rst_evt_a;
        logic [31:0] dv, tv;
        send(1'b0, 1'b1, 32'hFFFFFFFF, n);
        capture(1'b0, 16, dv, tv);
        checks++; if (tv[15:0] !== 16'hFAB0) begin errors++; $display("FAIL rstf_tms: got %h required fab0", tv[15:0]); end
        checks++; if (dv !== 32'h0) begin errors++; $display("FAIL rstf_data: got %h required 0", dv); end
        @(negedge clk);
        checks++; if ({a_done, a_tms, a_dat} !== 3'b100) begin errors++;
            $display("FAIL rstf_done: done/tms/dat %b required 100", {a_done, a_tms, a_dat}); end
        @(negedge clk);
        checks++; if ({a_busy, a_tms, a_dat} !== 3'b100) begin errors++;
            $display("FAIL rstf_gap: busy/tms/dat %b required 100", {a_busy, a_tms, a_dat}); end
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstf_idle: busy %b required 0", a_busy); end
        checks++; if (rst_evt_a - ev0 != 1 || got_a.size() != 0) begin errors++;
            $display("FAIL rstf_rx: resets %0d strobes %0d required 1 0", rst_evt_a - ev0, got_a.size()); end
        got_a.delete();
    endtask

    task automatic test_back_to_back();
        int n1 = -1, n2 = -1, low = 0;
        logic [31:0] e, g;
        exp_a.push_back(32'hDEADBEEF); exp_a.push_back(32'h00000001);
        @(negedge clk);
        a_valid = 1'b1; a_is_rst = 1'b0; a_data = 32'hDEADBEEF;
        for (int k = 0; k < 120 && n2 < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (n1 >= 0) a_data = 32'h00000001;
            if (a_ready) begin
                if (n1 < 0) n1 = cyc + 1; else n2 = cyc + 1;
            end else if (n1 >= 0) low++;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        checks++; if (n1 < 0 || n2 - n1 != 35) begin errors++;
            $display("FAIL b2b_spacing: got %0d required 35", n2 - n1); end
        checks++; if (low != 34) begin errors++; $display("FAIL b2b_ready_low: got %0d required 34", low); end
        wait_idle(1'b0);
        checks++; if (got_a.size() != 2) begin errors++; $display("FAIL b2b_strobes: got %0d required 2", got_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_word: got %h required %h", g, e); end
        end
        exp_a.delete(); got_a.delete();
    endtask

    task automatic test_sample_once();
        int n;
        logic [31:0] dv, tv, e, g;
        exp_a.push_back(32'hA5A5A5A5);
        send(1'b0, 1'b0, 32'hA5A5A5A5, n);
        a_data = 32'hFFFFFFFF;
        capture(1'b0, 32, dv, tv);
        checks++; if (dv !== 32'hA5A5A5A5) begin errors++; $display("FAIL sample_data: got %h required a5a5a5a5", dv); end
        wait_idle(1'b0);
        checks++; if (got_a.size() != 1) begin errors++; $display("FAIL sample_strobes: got %0d required 1", got_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL sample_word: got %h required %h", g, e); end
        end
        exp_a.delete(); got_a.delete();
    endtask

    task automatic test_abort();
        int n;
        logic [31:0] dv, tv, e, g;
        send(1'b0, 1'b0, 32'h3C3C3C3C, n);
        capture(1'b0, 11, dv, tv);
        checks++; if ({a_dat, a_busy} !== 2'b11) begin errors++;
            $display("FAIL abort_pre: dat/busy %b required 11", {a_dat, a_busy}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({a_tms, a_dat, a_busy, a_done} !== 4'b0) begin errors++;
            $display("FAIL abort_async: got %b required 0000", {a_tms, a_dat, a_busy, a_done}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (got_a.size() != 0 || a_busy !== 1'b0) begin errors++;
            $display("FAIL abort_rx: strobes %0d busy %b required 0 0", got_a.size(), a_busy); end
        got_a.delete();
        exp_a.push_back(32'h0F0F1234);
        send(1'b0, 1'b0, 32'h0F0F1234, n);
        wait_idle(1'b0);
        checks++; if (got_a.size() != 1) begin errors++; $display("FAIL abort_next_strobes: got %0d required 1", got_a.size()); end
        while (exp_a.size() > 0 && got_a.size() > 0) begin
            e = exp_a.pop_front(); g = got_a.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL abort_next_word: got %h required %h", g, e); end
        end
        exp_a.delete(); got_a.delete();
    endtask

    task automatic test_gap1();
        int n;
        logic [31:0] dv, tv, e, g;
        exp_b.push_back(32'h0000FAB1);
        send(1'b1, 1'b0, 32'h0000FAB1, n);
        capture(1'b1, 32, dv, tv);
        checks++; if (dv !== 32'h0000FAB1 || tv !== 32'h0000FAB1) begin errors++;
            $display("FAIL gap1_bits: data %h tms %h required 0000fab1 0000fab1", dv, tv); end
        @(negedge clk);
        checks++; if ({b_done, b_busy} !== 2'b11) begin errors++;
            $display("FAIL gap1_done: done/busy %b required 11", {b_done, b_busy}); end
        @(negedge clk);
        checks++; if ({b_done, b_busy, b_ready} !== 3'b001) begin errors++;
            $display("FAIL gap1_idle: done/busy/ready %b required 001", {b_done, b_busy, b_ready}); end
        repeat (4) @(negedge clk);
        checks++; if (got_b.size() != 1 || rst_evt_b != 0) begin errors++;
            $display("FAIL gap1_strobes: strobes %0d resets %0d required 1 0", got_b.size(), rst_evt_b); end
        while (exp_b.size() > 0 && got_b.size() > 0) begin
            e = exp_b.pop_front(); g = got_b.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL gap1_word: got %h required %h", g, e); end
        end
        exp_b.delete(); got_b.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_reset_frame();
        test_back_to_back();
        test_sample_once();
        test_abort();
        test_gap1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
